// File: rtl/halfband_pkg.sv
// rtl/halfband_pkg.sv - shared widths, Q15 pair coefficients and FSM state type for the half-band interpolator
package halfband_pkg;

  localparam int DATA_W    = 16;
  localparam int ACC_W     = 36;
  localparam int NUM_PAIRS = 8;
  localparam int COEF_W    = 16;
  localparam int CNT_W     = $clog2(NUM_PAIRS);

  // Symmetric pair coefficients, k = 0 outermost; they sum to 16384 so the FIR phase has unity DC gain.
  localparam logic signed [COEF_W-1:0] COEFS [NUM_PAIRS] = '{
    -16'sd12, 16'sd48, -16'sd140, 16'sd340, -16'sd740, 16'sd1520, -16'sd3280, 16'sd18648
  };

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    EMIT0,
    EMIT1
  } state_t;

endpackage

// File: rtl/halfband_round_sat.sv
// rtl/halfband_round_sat.sv - round-half-up Q15 scaling and saturation of the FIR accumulator
module halfband_round_sat
  import halfband_pkg::*;
(
  input  logic [ACC_W-1:0]  acc,
  output logic [DATA_W-1:0] data,
  output logic              sat
);

  localparam int SHIFT = 15;
  localparam int Q_W   = ACC_W - SHIFT;
  localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(1) << (SHIFT - 1);
  localparam logic signed [Q_W-1:0]   MAX_Q    = Q_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [Q_W-1:0]   MIN_Q    = -Q_W'(2 ** (DATA_W - 1));

  logic signed [ACC_W-1:0] sum;
  logic signed [Q_W-1:0]   q;

  always_comb begin
    sum  = $signed(acc) + HALF_LSB;
    q    = Q_W'(sum >>> SHIFT);
    data = q[DATA_W-1:0];
    sat  = 1'b0;
    if (q > MAX_Q) begin
      data = MAX_Q[DATA_W-1:0];
      sat  = 1'b1;
    end else if (q < MIN_Q) begin
      data = MIN_Q[DATA_W-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/halfband_interp2.sv
// rtl/halfband_interp2.sv - 2x half-band interpolator: one serial MAC per input, then FIR and centre-tap outputs
module halfband_interp2 #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 31
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_phase,
  output logic              out_sat
);
  import halfband_pkg::*;

  localparam int DLY_LEN = (TAPS + 1) / 2;
  localparam int IDX_W   = $clog2(DLY_LEN);
  localparam int CENTRE  = DLY_LEN / 2 - 1;
  localparam int PRE_W   = DATA_W + 1;
  localparam int PROD_W  = PRE_W + COEF_W;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic signed [DATA_W-1:0] d [DLY_LEN];
  logic signed [ACC_W-1:0]  acc;
  logic                     accept;
  logic [IDX_W-1:0]         idx_lo, idx_hi;
  logic signed [PRE_W-1:0]  pre_sum;
  logic signed [PROD_W-1:0] prod;
  logic [DATA_W-1:0]        rs_data;
  logic                     rs_sat;

  // Held low during reset so nothing upstream sees a ready before release.
  assign in_ready = (state == IDLE) && reset_n;
  assign accept   = in_valid && in_ready;

  assign idx_lo  = IDX_W'(cnt);
  assign idx_hi  = IDX_W'(DLY_LEN - 1) - idx_lo;
  assign pre_sum = PRE_W'(d[idx_lo]) + PRE_W'(d[idx_hi]);
  assign prod    = PROD_W'(pre_sum) * PROD_W'(COEFS[cnt]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      for (int k = 0; k < DLY_LEN; k++) d[k] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        for (int k = DLY_LEN - 1; k > 0; k--) d[k] <= d[k-1];
        d[0] <= in_data;
        acc  <= '0;
        cnt  <= '0;
      end else if (state == MAC) begin
        acc <= acc + ACC_W'(prod);
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_phase = 1'b0;
    out_data  = '0;
    out_sat   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = MAC;
      end
      MAC: begin
        if (cnt == CNT_W'(NUM_PAIRS - 1)) state_nxt = EMIT0;
      end
      EMIT0: begin
        out_valid = 1'b1;
        out_data  = rs_data;
        out_sat   = rs_sat;
        if (out_ready) state_nxt = EMIT1;
      end
      EMIT1: begin
        out_valid = 1'b1;
        out_phase = 1'b1;
        out_data  = d[CENTRE];
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  halfband_round_sat u_round_sat (
    .acc  (acc),
    .data (rs_data),
    .sat  (rs_sat)
  );

endmodule

// File: tb/tb_halfband_interp2.sv
// tb/tb_halfband_interp2.sv - scoreboard bench for the half-band interpolator
module tb_halfband_interp2;

  typedef struct {
    logic [15:0] data;
    logic        phase;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_phase;
  logic        out_sat;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  int   md [16];
  int   coef [8] = '{-12, 48, -140, 340, -740, 1520, -3280, 18648};

  halfband_interp2 #(.DATA_W(16), .TAPS(31)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_phase (out_phase),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got data=%0d phase=%0b, none expected", $signed(out_data), out_phase);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.data || out_phase !== e.phase || out_sat !== e.sat) begin
          n_fail++;
          $display("FAIL output: got data=%0d phase=%0b sat=%0b, expected data=%0d phase=%0b sat=%0b",
                   $signed(out_data), out_phase, out_sat, $signed(e.data), e.phase, e.sat);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_shift(input int x);
    for (int k = 15; k > 0; k--) md[k] = md[k-1];
    md[0] = x;
  endtask

  task automatic push_model();
    longint s = 0;
    longint r;
    exp_t   e;
    for (int k = 0; k < 8; k++) s += longint'(coef[k]) * longint'(md[k] + md[15-k]);
    r = (s + 16384) >>> 15;
    e.phase = 1'b0;
    e.sat   = 1'b0;
    if (r > 32767) begin
      r = 32767;  e.sat = 1'b1;
    end else if (r < -32768) begin
      r = -32768; e.sat = 1'b1;
    end
    e.data = 16'(r);
    exp_q.push_back(e);
    e.data  = 16'(md[7]);
    e.phase = 1'b1;
    e.sat   = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_exp(input int data, input logic phase, input logic sat);
    exp_t e;
    e.data  = 16'(data);
    e.phase = phase;
    e.sat   = sat;
    exp_q.push_back(e);
  endtask

  task automatic send(input int x);
    int n = 0;
    @(posedge clk); #1;
    in_data  = 16'(x);
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_shift(x);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d outputs outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({out_valid, out_phase, out_sat, in_ready} !== 4'b0000 || out_data !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b phase=%0b sat=%0b ready=%0b data=%0d, expected all 0",
               out_valid, out_phase, out_sat, in_ready, out_data);
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%0b out_valid=%0b, expected 1 and 0", in_ready, out_valid);
    end
  endtask

  task automatic test_impulse();
    int tab [16] = '{-6, 24, -70, 170, -370, 760, -1640, 9324, 9324, -1640, 760, -370, 170, -70, 24, -6};
    for (int m = 0; m < 16; m++) begin
      send(m == 0 ? 16384 : 0);
      push_exp(tab[m], 1'b0, 1'b0);
      push_exp(m == 7 ? 16384 : 0, 1'b1, 1'b0);
    end
    wait_drain("impulse");
  endtask

  task automatic test_dc();
    for (int m = 0; m < 20; m++) begin
      send(1000);
      if (m >= 16) begin
        push_exp(1000, 1'b0, 1'b0);
        push_exp(1000, 1'b1, 1'b0);
      end else begin
        push_model();
      end
    end
    wait_drain("dc");
  endtask

  task automatic test_saturation();
    for (int j = 0; j < 16; j++) begin
      int kk;
      kk = (j < 8) ? j : 15 - j;
      send(coef[kk] > 0 ? 32767 : -32768);
      if (j == 15) begin
        push_exp(32767, 1'b0, 1'b1);
        push_exp(32767, 1'b1, 1'b0);
      end else begin
        push_model();
      end
    end
    wait_drain("saturation");
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n = 0;
    out_ready = 1'b0;
    send(12345);
    push_model();
    e = exp_q[0];
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== e.data || out_phase !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold: valid=%0b data=%0d phase=%0b in_ready=%0b, expected 1 %0d 0 0",
                 out_valid, $signed(out_data), out_phase, in_ready, $signed(e.data));
      end
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 16'h8001;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain("backpressure");
    send(-2500);
    push_model();
    wait_drain("after_backpressure");
  endtask

  task automatic test_throughput();
    int cyc = 0, last = -1, n_acc = 0, n_ov = 0, val = 100;
    @(posedge clk); #1;
    in_data  = 16'(val);
    in_valid = 1'b1;
    while (cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (out_valid) n_ov++;
      if (in_ready) begin
        if (last >= 0) begin
          n_checks++;
          if (cyc - last != 11) begin
            n_fail++;
            $display("FAIL throughput_interval: got %0d cycles, expected 11", cyc - last);
          end
        end
        last = cyc;
        n_acc++;
        @(posedge clk); #1;
        model_shift(val);
        push_model();
        val += 777;
        in_data = 16'(val);
      end
    end
    in_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) n_ov++;
    end
    n_checks++;
    if (n_acc != 8 || n_ov != 2 * n_acc) begin
      n_fail++;
      $display("FAIL throughput_count: accepts=%0d valid_cycles=%0d, expected 8 and 16", n_acc, n_ov);
    end
    wait_drain("throughput");
  endtask

  task automatic test_reset_mid_mac();
    send(5000);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_phase, out_sat, in_ready} !== 4'b0000 || out_data !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_mac: valid=%0b phase=%0b sat=%0b ready=%0b data=%0d, expected all 0",
               out_valid, out_phase, out_sat, in_ready, out_data);
    end
    exp_q.delete();
    for (int k = 0; k < 16; k++) md[k] = 0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_mac_release: in_ready=%0b out_valid=%0b, expected 1 and 0", in_ready, out_valid);
    end
    test_impulse();
  endtask

  initial begin
    for (int k = 0; k < 16; k++) md[k] = 0;
    test_reset();
    test_impulse();
    test_dc();
    test_saturation();
    test_backpressure();
    test_throughput();
    test_reset_mid_mac();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
